// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: funct3 encodings and access-size decode.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned SIZE_W = 3;

  // Byte count of an access from funct3[1:0]; the reserved code is treated as a word.
  function automatic logic [SIZE_W-1:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SIZE_W'(1);
      2'b01:   return SIZE_W'(2);
      default: return SIZE_W'(4);
    endcase
  endfunction

  // Load encodings that may be satisfied from buffered store data.
  function automatic logic ld_f3_known(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Compares one buffered store's byte range against the current load's byte range.
module sb_overlap_check #(
  parameter int unsigned RW = 10
) (
  input  logic [RW-1:0] i_e_lo,
  input  logic [RW-1:0] i_e_hi,
  input  logic [RW-1:0] i_l_lo,
  input  logic [RW-1:0] i_l_hi,
  output logic          o_hit,
  output logic          o_exact
);

  // Ranges are inclusive and computed one bit wider than the address, so they never wrap.
  assign o_hit   = (i_e_lo <= i_l_hi) && (i_l_lo <= i_e_hi);
  assign o_exact = o_hit && (i_e_lo == i_l_lo) && (i_e_hi >= i_l_hi);

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM and the unified memory; drains in data cycles and
// forwards or stalls MEM-stage loads that overlap pending stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_slow,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_funct3,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_funct3,
  output logic          ld_fwd_valid,
  output logic [31:0]   ld_fwd_data,
  output logic          ld_stall,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic [2:0]    mem_funct3,
  output logic          empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned RW = AW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    funct3;
  } sb_entry_t;

  sb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_count;
  sb_entry_t       w_head;
  logic [RW-1:0]   w_l_lo;
  logic [RW-1:0]   w_l_hi;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_exact;
  logic            w_any_hit;
  logic            w_sel_exact;
  logic [31:0]     w_sel_data;
  logic            w_fwd_ok;

  // Extra pointer MSB separates full from empty.
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
  assign st_ready = !w_full;
  assign w_push   = st_valid && !w_full;
  assign w_count  = r_wr_ptr - r_rd_ptr;

  // Drain only while the shared memory port is in its data phase.
  assign w_head     = r_mem[r_rd_ptr[IW-1:0]];
  assign mem_write  = !empty && !clk_slow;
  assign w_pop      = mem_write;
  assign mem_addr   = mem_write ? w_head.addr   : '0;
  assign mem_data   = mem_write ? w_head.data   : '0;
  assign mem_funct3 = mem_write ? w_head.funct3 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Payload storage needs no reset: slots are only read while the pointers mark them live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IW-1:0]] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
  end

  assign w_l_lo = {1'b0, ld_addr};
  assign w_l_hi = w_l_lo + RW'(f3_size(ld_funct3)) - RW'(1);

  for (genvar j = 0; j < DEPTH; j++) begin : g_ovl
    logic [RW-1:0] w_e_lo;
    logic [RW-1:0] w_e_hi;
    assign w_e_lo = {1'b0, r_mem[j].addr};
    assign w_e_hi = w_e_lo + RW'(f3_size(r_mem[j].funct3)) - RW'(1);
    sb_overlap_check #(.RW(RW)) u_ovl (
      .i_e_lo  (w_e_lo),
      .i_e_hi  (w_e_hi),
      .i_l_lo  (w_l_lo),
      .i_l_hi  (w_l_hi),
      .o_hit   (w_hit[j]),
      .o_exact (w_exact[j])
    );
  end

  // Walk live entries oldest to youngest so the youngest overlapping one wins.
  always_comb begin
    w_any_hit   = 1'b0;
    w_sel_exact = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW'(i) < w_count) && w_hit[IW'(r_rd_ptr[IW-1:0] + IW'(i))]) begin
        w_any_hit   = 1'b1;
        w_sel_exact = w_exact[IW'(r_rd_ptr[IW-1:0] + IW'(i))];
        w_sel_data  = r_mem[IW'(r_rd_ptr[IW-1:0] + IW'(i))].data;
      end
    end
  end

  assign w_fwd_ok     = w_any_hit && w_sel_exact && ld_f3_known(ld_funct3);
  assign ld_fwd_valid = ld_valid && w_fwd_ok;
  assign ld_stall     = ld_valid && w_any_hit && !w_fwd_ok;

  always_comb begin
    ld_fwd_data = '0;
    if (ld_fwd_valid) begin
      case (ld_funct3)
        F3_LB:   ld_fwd_data = {{24{w_sel_data[7]}}, w_sel_data[7:0]};
        F3_LH:   ld_fwd_data = {{16{w_sel_data[15]}}, w_sel_data[15:0]};
        F3_LW:   ld_fwd_data = w_sel_data;
        F3_LBU:  ld_fwd_data = {24'd0, w_sel_data[7:0]};
        F3_LHU:  ld_fwd_data = {16'd0, w_sel_data[15:0]};
        default: ld_fwd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain timing, full handling,
// forwarding/extension, stall on partial overlap, youngest-wins and async reset.
module tb_store_buffer;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_slow;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_funct3;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic          ld_fwd_valid;
  logic [31:0]   ld_fwd_data;
  logic          ld_stall;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [2:0]    mem_funct3;
  logic          empty;

  int n_chk = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_slow(clk_slow),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .mem_funct3(mem_funct3),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    step();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [2:0] f3);
    ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clk_slow = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);
    rst_n = 1'b1;
    step();

    // Single store held through fetch phases, then drained.
    push(9'h040, 32'hDEADBEEF, 3'b010);
    for (int i = 0; i < 3; i++) begin
      chk("hold_mem_write", 32'(mem_write), 32'd0);
      chk("hold_empty", 32'(empty), 32'd0);
      step();
    end
    clk_slow = 1'b0; #1;
    chk("drain_mem_write", 32'(mem_write), 32'd1);
    chk("drain_mem_addr", 32'(mem_addr), 32'h40);
    chk("drain_mem_data", mem_data, 32'hDEADBEEF);
    chk("drain_mem_funct3", 32'(mem_funct3), 32'd2);
    step();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_mem_write_off", 32'(mem_write), 32'd0);
    clk_slow = 1'b1;

    // Fill to capacity; fifth store refused.
    push(9'h080, 32'hA0, 3'b010); chk("fill1_ready", 32'(st_ready), 32'd1);
    push(9'h084, 32'hA1, 3'b010); chk("fill2_ready", 32'(st_ready), 32'd1);
    push(9'h088, 32'hA2, 3'b010); chk("fill3_ready", 32'(st_ready), 32'd1);
    push(9'h08C, 32'hA3, 3'b010); chk("fill4_ready", 32'(st_ready), 32'd0);
    push(9'h090, 32'hBAD, 3'b010); chk("fill5_ready", 32'(st_ready), 32'd0);
    clk_slow = 1'b0; #1;
    chk("fifo0_addr", 32'(mem_addr), 32'h80);
    chk("fifo0_data", mem_data, 32'hA0);
    step();
    chk("fifo_ready_after_pop", 32'(st_ready), 32'd1);
    chk("fifo1_addr", 32'(mem_addr), 32'h84);
    step();
    chk("fifo2_addr", 32'(mem_addr), 32'h88);
    step();
    chk("fifo3_addr", 32'(mem_addr), 32'h8C);
    chk("fifo3_data", mem_data, 32'hA3);
    step();
    chk("fifo_drained_empty", 32'(empty), 32'd1);
    chk("fifo_no_fifth", 32'(mem_write), 32'd0);
    clk_slow = 1'b1;

    // Forwarding with extension from a pending word store.
    push(9'h100, 32'h1234F680, 3'b010);
    load(9'h100, 3'b000);
    chk("lb_fwd_valid", 32'(ld_fwd_valid), 32'd1);
    chk("lb_fwd_data", ld_fwd_data, 32'hFFFFFF80);
    chk("lb_stall", 32'(ld_stall), 32'd0);
    load(9'h100, 3'b100);
    chk("lbu_fwd_data", ld_fwd_data, 32'h00000080);
    chk("lbu_stall", 32'(ld_stall), 32'd0);
    load(9'h100, 3'b010);
    chk("lw_fwd_data", ld_fwd_data, 32'h1234F680);
    chk("lw_stall", 32'(ld_stall), 32'd0);
    load(9'h100, 3'b001);
    chk("lh_fwd_data", ld_fwd_data, 32'hFFFFF680);
    load(9'h101, 3'b000);
    chk("lb_offset_stall", 32'(ld_stall), 32'd1);
    chk("lb_offset_fwd", 32'(ld_fwd_valid), 32'd0);
    load(9'h100, 3'b011);
    chk("unknown_f3_stall", 32'(ld_stall), 32'd1);
    ld_valid = 1'b0; #1;
    chk("no_ld_stall", 32'(ld_stall), 32'd0);
    clk_slow = 1'b0;
    step();
    clk_slow = 1'b1;

    // Partial overlap stalls until the byte store drains.
    push(9'h101, 32'h000000AA, 3'b000);
    load(9'h100, 3'b010);
    chk("partial_stall", 32'(ld_stall), 32'd1);
    chk("partial_fwd", 32'(ld_fwd_valid), 32'd0);
    step();
    chk("partial_stall_hold", 32'(ld_stall), 32'd1);
    clk_slow = 1'b0;
    step();
    chk("partial_stall_clear", 32'(ld_stall), 32'd0);
    chk("partial_fwd_clear", 32'(ld_fwd_valid), 32'd0);
    ld_valid = 1'b0;
    clk_slow = 1'b1;

    // Youngest overlapping store wins; neighbouring word is untouched.
    push(9'h020, 32'h11111111, 3'b010);
    push(9'h020, 32'h22222222, 3'b010);
    load(9'h020, 3'b010);
    chk("youngest_fwd_valid", 32'(ld_fwd_valid), 32'd1);
    chk("youngest_fwd_data", ld_fwd_data, 32'h22222222);
    // Same-edge store to the load address is not yet visible.
    st_valid = 1'b1; st_addr = 9'h024; st_data = 32'h33333333; st_funct3 = 3'b010;
    load(9'h024, 3'b010);
    chk("neighbour_fwd", 32'(ld_fwd_valid), 32'd0);
    chk("neighbour_stall", 32'(ld_stall), 32'd0);
    step();
    st_valid = 1'b0; #1;
    chk("pushed_now_fwd", ld_fwd_data, 32'h33333333);
    ld_valid = 1'b0;

    // Async reset in the middle of draining three entries.
    clk_slow = 1'b0; #1;
    chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
    chk("pre_rst_mem_addr", 32'(mem_addr), 32'h20);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_mem_data", mem_data, 32'd0);
    chk("mid_rst_st_ready", 32'(st_ready), 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_write", 32'(mem_write), 32'd0);
    end

    // Push-to-write latency and simultaneous push/pop.
    st_valid = 1'b1; st_addr = 9'h044; st_data = 32'h55; st_funct3 = 3'b010; #1;
    chk("lat_before_edge", 32'(mem_write), 32'd0);
    step();
    chk("lat_after_edge", 32'(mem_write), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'h44);
    st_addr = 9'h048; st_data = 32'h66;
    step();
    st_valid = 1'b0; #1;
    chk("pushpop_addr", 32'(mem_addr), 32'h48);
    chk("pushpop_data", mem_data, 32'h66);
    step();
    chk("pushpop_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue between the EX/MEM pipeline register and the unified byte-addressed Memory (512 B, shared instruction/data port).
- Accepts stores from the MEM stage without stalling the pipeline.
- Drains stores into Memory only in data cycles (clk_slow low), so they never collide with instruction fetch.
- Checks MEM-stage loads against pending stores: forwards store data to the load, or requests a stall.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, ≥2)
AW, 9, byte address width (matches Memory addr)

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
clk_slow  in  1  fetch phase when high; drain allowed only when low
st_valid  in  1  MEM-stage store request (MemWrite)
st_addr  in  AW  store byte address
st_data  in  32  store data (rs2 value)
st_funct3  in  3  F3_SB / F3_SH / F3_SW
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  MEM-stage load request (MemRead)
ld_addr  in  AW  load byte address
ld_funct3  in  3  F3_LB/LH/LW/LBU/LHU
ld_fwd_valid  out  1  ld_fwd_data replaces Memory data_out
ld_fwd_data  out  32  forwarded, extended load result
ld_stall  out  1  hold MEM stage; load overlaps a pending store that cannot be forwarded
mem_write  out  1  to Memory MemWrite
mem_addr  out  AW  to Memory addr in data cycles
mem_data  out  32  to Memory data_in
mem_funct3  out  3  to Memory funct3
empty  out  1  no pending stores (used by ECALL/halt to wait for drain)

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, funct3}.
  - Pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Reset (async, rst_n=0): pointers cleared; all queued entries discarded, including mid-drain.
  - Outputs during/after reset: empty=1, st_ready=1, mem_write=0, ld_fwd_valid=0, ld_stall=0, mem_addr/mem_data/mem_funct3=0.
- Push: st_valid && st_ready at posedge writes the tail and advances it.
  - st_ready = !full. Capacity is evaluated without pop bypass, so a full buffer refuses a push even in a pop cycle.
  - st_valid while !st_ready is ignored by the buffer; the pipeline is required to stall on !st_ready.
- Drain: mem_write = !empty && !clk_slow. mem_addr/data/funct3 are driven combinationally from the head entry; all zero when mem_write=0.
  - The head pops at the posedge where mem_write=1.
  - Minimum push-to-write latency: 1 cycle. An entry pushed at edge N can be written at edge N+1 at the earliest.
  - Push and pop at the same edge are both performed.
- Byte ranges: size = 1/2/4 from funct3[1:0].
  - Range is [addr, addr+size-1], computed in AW+1 bits with no wrap.
  - Pipeline guarantees natural alignment; the buffer does not check it.
- Load check (combinational, only when ld_valid): find the youngest entry whose range intersects the load range.
  - No overlap: ld_fwd_valid=0, ld_stall=0; Memory serves the load.
  - Youngest overlap has entry.addr == ld_addr and store size ≥ load size: ld_fwd_valid=1, ld_stall=0.
    - ld_fwd_data = low load-size bytes of entry data.
    - Extension: sign for LB/LH, zero for LBU/LHU, none for LW.
  - Any other overlap (partial or offset): ld_stall=1, ld_fwd_valid=0. The stall persists until drain removes all overlapping entries.
  - Older overlapping entries are ignored once a younger one qualifies.
- Same-cycle load and store: the load checks only entries present before this edge; the incoming store is not visible.
- ld_valid=0: ld_fwd_valid=0, ld_stall=0.
- Unknown funct3: loads are treated as non-forwardable on overlap, so they stall. Store funct3 is passed unchanged to Memory.

Decomposition:
- Shared defines.v holds:
  - F3_* funct3 constants (already there).
  - A new size-decode macro/function (funct3 → byte count).
- One sub-module, sb_overlap_check: one instance per entry.
  - Inputs: entry range, load range.
  - Outputs: hit, exact-match-and-covers.
- Youngest-hit priority select lives in store_buffer.

Test Plan:
- Reset then SW addr 0x40 data 0xDEADBEEF, clk_slow=1 for 3 cycles → mem_write stays 0, empty=0. Lower clk_slow → mem_write=1, mem_addr=0x40, mem_data=0xDEADBEEF for one cycle; then empty=1.
- Four SW pushes with clk_slow held high → st_ready=0 after the 4th; a 5th st_valid is not queued. Lower clk_slow → 4 writes in FIFO order over 4 data cycles; st_ready returns 1 after the first pop.
- Pending SW 0x100 = 0x1234F680, then LB 0x100 → ld_fwd_valid=1, ld_fwd_data=0xFFFFFF80. LBU 0x100 → 0x00000080. LW 0x100 → 0x1234F680. No stall in any case.
- Pending SB 0x101 = 0xAA, then LW 0x100 → ld_stall=1 until the SB drains, then ld_stall=0, ld_fwd_valid=0.
- Pending SW 0x20 = 0x11111111, then SW 0x20 = 0x22222222, then LW 0x20 → forwards 0x22222222 (youngest wins). LW 0x24 → no overlap, no stall.
- rst_n pulsed low mid-drain with 3 entries → outputs go to reset values immediately; after release, no further mem_write occurs.
